// File: rtl/life_pkg.sv
// Shared constants, state encoding and cell indexing for the Game of Life engine.
package life_pkg;

    localparam int LIFE_ROWS   = 8;
    localparam int LIFE_COLS   = 8;
    localparam int LIFE_GRID_W = LIFE_ROWS * LIFE_COLS;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        FINISH  = 2'd2
    } state_e;

    function automatic int cell_idx(input int r, input int c, input int cols);
        return r * cols + c;
    endfunction

endpackage

// File: rtl/life_row_next.sv
// Combinational next-state of one grid row from the rows above, at and below it.
module life_row_next #(
    parameter int COLS = 8,
    parameter int WRAP = 0
) (
    input  logic [COLS-1:0] above,
    input  logic [COLS-1:0] cur,
    input  logic [COLS-1:0] below,
    output logic [COLS-1:0] nxt
);

    for (genvar c = 0; c < COLS; c++) begin : g_col
        localparam int CL    = (c == 0) ? COLS - 1 : c - 1;
        localparam int CR    = (c == COLS - 1) ? 0 : c + 1;
        // Border columns only see their outer neighbours when the grid is toroidal.
        localparam bit HAS_L = (WRAP != 0) || (c != 0);
        localparam bit HAS_R = (WRAP != 0) || (c != COLS - 1);

        logic [3:0] n;

        always_comb begin
            n = 4'(above[c]) + 4'(below[c]);
            if (HAS_L) n = n + 4'(above[CL]) + 4'(cur[CL]) + 4'(below[CL]);
            if (HAS_R) n = n + 4'(above[CR]) + 4'(cur[CR]) + 4'(below[CR]);
        end

        assign nxt[c] = (n == 4'd3) || (cur[c] && (n == 4'd2));
    end

endmodule

// File: rtl/life_gen_engine.sv
// Row-serial Game of Life generation engine: snapshots a grid on start, evolves
// one row per cycle, then publishes the result with generation/status flags.
module life_gen_engine
    import life_pkg::*;
#(
    parameter int ROWS  = LIFE_ROWS,
    parameter int COLS  = LIFE_COLS,
    parameter int WRAP  = 0,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ROWS*COLS-1:0] grid_in,
    output logic                 busy,
    output logic                 done,
    output logic [ROWS*COLS-1:0] grid_out,
    output logic [CNT_W-1:0]     gen_count,
    output logic                 stable,
    output logic                 extinct
);

    localparam int GW    = ROWS * COLS;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    state_e           state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [GW-1:0]    src_q, src_d;
    logic [GW-1:0]    dst_q, dst_d;
    logic [GW-1:0]    grid_out_q, grid_out_d;
    logic [CNT_W-1:0] gen_count_q, gen_count_d;
    logic             stable_q, stable_d;
    logic             extinct_q, extinct_d;

    logic [COLS-1:0]  above, cur, below, nxt;
    logic [GW-1:0]    dst_new;

    // Neighbour rows for the current row; off-grid rows are dead unless wrapping.
    always_comb begin
        int r;
        r     = int'(row_q);
        cur   = src_q[cell_idx(r, 0, COLS) +: COLS];
        above = '0;
        below = '0;
        if (r > 0)          above = src_q[cell_idx(r - 1, 0, COLS) +: COLS];
        else if (WRAP != 0) above = src_q[cell_idx(ROWS - 1, 0, COLS) +: COLS];
        if (r < ROWS - 1)   below = src_q[cell_idx(r + 1, 0, COLS) +: COLS];
        else if (WRAP != 0) below = src_q[cell_idx(0, 0, COLS) +: COLS];
        dst_new = dst_q;
        dst_new[cell_idx(r, 0, COLS) +: COLS] = nxt;
    end

    life_row_next #(
        .COLS (COLS),
        .WRAP (WRAP)
    ) u_row_next (
        .above (above),
        .cur   (cur),
        .below (below),
        .nxt   (nxt)
    );

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        src_d       = src_q;
        dst_d       = dst_q;
        grid_out_d  = grid_out_q;
        gen_count_d = gen_count_q;
        stable_d    = stable_q;
        extinct_d   = extinct_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    src_d   = grid_in;
                    dst_d   = '0;
                    row_d   = '0;
                    state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                dst_d = dst_new;
                // Publish on the last row so results are already valid during FINISH.
                if (row_q == ROW_W'(ROWS - 1)) begin
                    row_d       = '0;
                    grid_out_d  = dst_new;
                    gen_count_d = gen_count_q + 1'b1;
                    stable_d    = (dst_new == src_q);
                    extinct_d   = (dst_new == '0);
                    state_d     = FINISH;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            row_q       <= '0;
            src_q       <= '0;
            dst_q       <= '0;
            grid_out_q  <= '0;
            gen_count_q <= '0;
            stable_q    <= 1'b0;
            extinct_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            grid_out_q  <= grid_out_d;
            gen_count_q <= gen_count_d;
            stable_q    <= stable_d;
            extinct_q   <= extinct_d;
        end
    end

    assign busy      = (state_q == COMPUTE);
    assign done      = (state_q == FINISH);
    assign grid_out  = grid_out_q;
    assign gen_count = gen_count_q;
    assign stable    = stable_q;
    assign extinct   = extinct_q;

endmodule

// File: tb/tb_life_gen_engine.sv
// Bench for life_gen_engine: bounded and toroidal instances share stimulus and
// are compared against a cell-by-cell neighbour-counting reference.
module tb_life_gen_engine;

    localparam logic [63:0] BLINKER = 64'h0000_0000_1C00_0000;
    localparam logic [63:0] BLINK_V = 64'h0000_0008_0808_0000;
    localparam logic [63:0] BLOCK   = 64'h0000_0000_0000_0303;
    localparam logic [63:0] CORNERS = 64'h8100_0000_0000_0081;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [63:0] grid_in;
    logic        busy0, done0, stable0, extinct0;
    logic        busy1, done1, stable1, extinct1;
    logic [63:0] gout0, gout1;
    logic [15:0] gc0, gc1;

    int n_chk  = 0;
    int n_pass = 0;
    int exp_gen = 0;

    life_gen_engine #(.WRAP(0)) dut0 (
        .clk(clk), .reset(reset), .start(start), .grid_in(grid_in),
        .busy(busy0), .done(done0), .grid_out(gout0), .gen_count(gc0),
        .stable(stable0), .extinct(extinct0)
    );

    life_gen_engine #(.WRAP(1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .grid_in(grid_in),
        .busy(busy1), .done(done1), .grid_out(gout1), .gen_count(gc1),
        .stable(stable1), .extinct(extinct1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: count the eight neighbours of every cell directly.
    function automatic logic [63:0] ref_next(input logic [63:0] g, input bit wrap);
        logic [63:0] res;
        int n, rr, cc;
        res = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        rr = r + dr;
                        cc = c + dc;
                        if (wrap) begin
                            rr = (rr + 8) % 8;
                            cc = (cc + 8) % 8;
                        end
                        if (!(dr == 0 && dc == 0) && rr >= 0 && rr < 8 && cc >= 0 && cc < 8)
                            n += int'(g[rr*8+cc]);
                    end
                end
                res[r*8+c] = g[r*8+c] ? (n == 2 || n == 3) : (n == 3);
            end
        end
        return res;
    endfunction

    // One full step on both instances, scrambling grid_in while the step is in flight.
    task automatic run_step(input logic [63:0] g);
        int cnt;
        logic [63:0] e0, e1;
        e0 = ref_next(g, 1'b0);
        e1 = ref_next(g, 1'b1);
        grid_in = g;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        grid_in = {$urandom, $urandom};
        cnt = 1;
        while (!done0 && cnt < 20) begin
            tick();
            cnt++;
        end
        exp_gen++;
        chk("latency", 64'(cnt), 64'd9);
        chk("done_wrap_sync", 64'(done1), 64'd1);
        chk("busy_at_done", 64'(busy0 | busy1), 64'd0);
        chk("grid_nowrap", gout0, e0);
        chk("grid_wrap", gout1, e1);
        chk("stable_nowrap", 64'(stable0), 64'(e0 == g));
        chk("stable_wrap", 64'(stable1), 64'(e1 == g));
        chk("extinct_nowrap", 64'(extinct0), 64'(e0 == 64'd0));
        chk("extinct_wrap", 64'(extinct1), 64'(e1 == 64'd0));
        chk("gen_count", 64'(gc0), 64'(exp_gen[15:0]));
        chk("gen_count_wrap", 64'(gc1), 64'(exp_gen[15:0]));
        tick();
        chk("done_one_cycle", 64'(done0 | done1), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        grid_in = '0;
        tick();
        tick();
        chk("rst_grid", gout0 | gout1, 64'd0);
        chk("rst_gen", 64'(gc0 | gc1), 64'd0);
        chk("rst_flags", 64'({busy0, done0, stable0, extinct0, busy1, done1, stable1, extinct1}), 64'd0);
        reset = 1'b0;
        tick();

        // Directed patterns
        run_step(BLINKER);
        chk("blinker_v", gout0, BLINK_V);
        chk("blinker_stable", 64'(stable0), 64'd0);
        run_step(BLINK_V);
        chk("blinker_h", gout0, BLINKER);
        chk("blinker_gen2", 64'(gc0), 64'd2);
        run_step(BLOCK);
        chk("block", gout0, BLOCK);
        chk("block_stable", 64'({stable0, extinct0}), 64'b10);
        run_step(CORNERS);
        chk("corner_wrap", gout1, CORNERS);
        chk("corner_wrap_stable", 64'(stable1), 64'd1);
        chk("corner_nowrap", gout0, 64'd0);
        chk("corner_nowrap_extinct", 64'(extinct0), 64'd1);
        run_step(64'd0);
        chk("empty_flags", 64'({stable0, extinct0, stable1, extinct1}), 64'hF);

        // start held high: one result every 10 cycles, busy and done exclusive
        begin
            int last, pulses;
            last = -1;
            pulses = 0;
            grid_in = BLINKER;
            start = 1'b1;
            for (int cyc = 0; cyc < 60 && pulses < 3; cyc++) begin
                tick();
                chk("busy_done_excl", 64'(busy0 & done0), 64'd0);
                if (done0) begin
                    exp_gen++;
                    pulses++;
                    chk("held_grid", gout0, BLINK_V);
                    chk("held_gen", 64'(gc0), 64'(exp_gen[15:0]));
                    if (last >= 0) chk("held_period", 64'(cyc - last), 64'd10);
                    last = cyc;
                    if (pulses == 3) start = 1'b0;
                end
            end
            chk("held_pulses", 64'(pulses), 64'd3);
            tick();
        end

        // Randomized grids at assorted densities, plus chained generations
        for (int i = 0; i < 24; i++) begin
            logic [63:0] g;
            g = {$urandom, $urandom};
            case (i % 4)
                0: g = g & {$urandom, $urandom};
                1: g = g & {$urandom, $urandom} & {$urandom, $urandom};
                2: g = g | {$urandom, $urandom};
                default: ;
            endcase
            run_step(g);
            if (i % 6 == 5) run_step(gout1);
        end

        // Reset in the middle of a step: abort, no done, outputs cleared at once
        grid_in = BLINKER;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_grid", gout0 | gout1, 64'd0);
        chk("mid_rst_gen", 64'(gc0 | gc1), 64'd0);
        chk("mid_rst_flags", 64'({busy0, done0, stable0, extinct0, busy1, done1, stable1, extinct1}), 64'd0);
        begin
            int seen;
            seen = 0;
            for (int k = 0; k < 12; k++) begin
                tick();
                if (done0 | done1) seen++;
            end
            chk("mid_rst_no_done", 64'(seen), 64'd0);
        end
        reset = 1'b0;
        exp_gen = 0;
        tick();
        run_step(BLINKER);
        chk("after_rst_gen1", 64'(gc0), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/life_gen_engine.md
Name: life_gen_engine

Overview:
- Sequential next-generation engine for the 8x8 Game of Life grid.
- Sits directly downstream of the init/evolve grid select: consumes the selected 64-bit grid and produces the evolved grid fed back to that select.
- Computes one row per cycle under a start/done handshake.
- Also reports generation count, still-life and extinction status.

Parameters:
ROWS, 8, grid rows
COLS, 8, grid columns; grid width is ROWS*COLS
WRAP, 0, 0 = cells beyond the border are dead; 1 = toroidal wrap on both axes
CNT_W, 16, width of generation counter

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  request one generation step; sampled only in IDLE
grid_in  in  ROWS*COLS  current grid; cell (r,c) = bit r*COLS+c (row 0 = bits 7:0, col 0 = LSB)
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse; grid_out is valid in the same cycle
grid_out  out  ROWS*COLS  last computed generation; held between steps
gen_count  out  CNT_W  number of completed generations
stable  out  1  last result equals its source grid
extinct  out  1  last result is all zero

Behaviour:
- Reset (async): state IDLE; busy=0, done=0, grid_out=0, gen_count=0, stable=0, extinct=0; row counter and scratch registers cleared.
- Reset asserted mid-computation aborts the step. No done is produced and outputs take their reset values.
- States: IDLE, COMPUTE, FINISH.
- IDLE, start=1 at edge of cycle t:
  - snapshot grid_in into src register;
  - row=0;
  - go to COMPUTE.
- IDLE, start=0: remain in IDLE; done=0.
- COMPUTE, one row per cycle (cycles t+1 .. t+ROWS):
  - dst row[row] = next-state of src rows row-1, row, row+1;
  - row increments;
  - after the row=ROWS-1 cycle, go to FINISH.
- FINISH (cycle t+ROWS+1):
  - done=1, busy=0;
  - grid_out=dst;
  - gen_count+1 (wraps modulo 2^CNT_W);
  - stable=(dst==src);
  - extinct=(dst==0);
  - return to IDLE next cycle.
- Latency: done asserted exactly ROWS+1 cycles after start is sampled (9 for the default grid).
- Outputs grid_out, stable and extinct are registered. They change only at FINISH or reset.
- start while in COMPUTE or FINISH is ignored; it is not queued.
- grid_in changes after the snapshot have no effect on the step in flight.
- Back-to-back: start high in the cycle after FINISH begins the next step. Max throughput is one generation per ROWS+2 cycles.
- Rule per cell, with n = live neighbour count (0..8, 4-bit, no overflow):
  - live cell survives iff n is 2 or 3;
  - dead cell is born iff n is 3;
  - otherwise the cell is dead.
- WRAP=0: row -1, row ROWS, col -1 and col COLS read as 0.
- WRAP=1: indices are taken modulo ROWS/COLS. Row 0 neighbours row ROWS-1; col 0 neighbours col COLS-1.

Decomposition:
- Package life_pkg:
  - ROWS/COLS default constants;
  - grid width localparam;
  - state typedef enum {IDLE, COMPUTE, FINISH};
  - cell-index function r*COLS+c.
- Sub-module life_row_next (combinational):
  - inputs: above, cur, below rows (COLS bits each) and WRAP;
  - output: next row (COLS bits);
  - contains the neighbour adder and rule logic.
- life_gen_engine instantiates one life_row_next and holds the FSM, row counter, src/dst registers and status logic.

Test Plan:
- Blinker, WRAP=0: grid_in=0x0000_0000_1C00_0000, start -> done at t+9, grid_out=0x0000_0008_0808_0000, stable=0, gen_count=1. Second step returns 0x0000_0000_1C00_0000, gen_count=2.
- Block still life: grid_in=0x0000_0000_0000_0303 -> grid_out=0x303, stable=1, extinct=0.
- Corner cells 0x8100_0000_0000_0081:
  - WRAP=1 -> grid_out unchanged, stable=1;
  - WRAP=0 -> grid_out=0, extinct=1.
- Empty grid: grid_in=0 -> grid_out=0, stable=1, extinct=1, done still pulses once.
- start held high continuously with blinker: done pulses every 10 cycles, busy never asserts in the same cycle as done. grid_in changes during COMPUTE do not alter the result.
- Reset asserted at cycle t+4 of a step: no done pulse; all outputs return to 0 immediately. A new start after reset release completes normally with gen_count=1.
